// File: rtl/imem_loader.sv
// imem_loader
// Boot-time instruction memory loader. Accepts a byte stream framed as
// N[15:8], N[7:0], N big-endian 16-bit words, then one XOR checksum byte
// over the 2N data bytes. Each assembled word is written through a
// synchronous memory write port. The CPU is kept in reset until a frame
// with a matching checksum has been loaded.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle load request, honoured in IDLE or DONE only
//   in_data    stream byte
//   in_valid   stream byte valid
//   in_ready   loader accepts a byte this cycle (depends on state only)
//   mem_we     instruction memory write enable (one-cycle pulse)
//   mem_addr   instruction memory word address
//   mem_wdata  instruction memory write data
//   cpu_rst    processor reset, 1 = held in reset
//   busy       load in progress
//   done       load finished (pass or fail), held until next start
//   err        load failed, held until next start
module imem_loader #(
  parameter int ADDR_W = 8  // supported range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CSUM,
    S_DONE
  } state_t;

  // Largest legal word count: the memory depth itself.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t            state_reg, state_next;
  logic [15:0]       len_reg, len_next;
  logic [ADDR_W:0]   index_reg, index_next;
  logic [7:0]        hi_reg, hi_next;
  logic [7:0]        csum_reg, csum_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [15:0]       wdata_reg, wdata_next;
  logic              cpu_rst_reg, cpu_rst_next;
  logic              err_reg, err_next;

  logic              accept;
  logic [15:0]       len_full;
  logic [15:0]       index_ext;
  logic              last_word;

  // in_ready is a pure function of state so it never loops back to in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM: in_ready = 1'b1;
      default:                                          in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  // Length as it will be once the low byte currently on the bus is latched.
  assign len_full  = {len_reg[15:8], in_data};
  assign index_ext = 16'(index_reg);
  // Length is known nonzero whenever WRITE is reached, so len-1 cannot wrap.
  assign last_word = (index_ext == (len_reg - 16'd1));

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    index_next   = index_reg;
    hi_next      = hi_reg;
    csum_next    = csum_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    cpu_rst_next = cpu_rst_reg;
    err_next     = err_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next   = S_LEN_HI;
          cpu_rst_next = 1'b1;
          err_next     = 1'b0;
          csum_next    = 8'd0;
          index_next   = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_next   = {in_data, len_reg[7:0]};
          state_next = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_next = len_full;
          if (len_full == 16'd0 || {1'b0, len_full} > DEPTH) begin
            state_next = S_DONE;
            err_next   = 1'b1;
          end else begin
            state_next = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_next    = in_data;
          csum_next  = csum_reg ^ in_data;
          state_next = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          wdata_next = {hi_reg, in_data};
          addr_next  = index_reg[ADDR_W-1:0];
          csum_next  = csum_reg ^ in_data;
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_next = S_CSUM;
        end else begin
          index_next = index_reg + 1'b1;
          state_next = S_DATA_HI;
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_next = S_DONE;
          if (in_data == csum_reg) begin
            err_next     = 1'b0;
            cpu_rst_next = 1'b0;
          end else begin
            err_next     = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      len_reg     <= 16'd0;
      index_reg   <= '0;
      hi_reg      <= 8'd0;
      csum_reg    <= 8'd0;
      addr_reg    <= '0;
      wdata_reg   <= 16'd0;
      cpu_rst_reg <= 1'b1;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      index_reg   <= index_next;
      hi_reg      <= hi_next;
      csum_reg    <= csum_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      cpu_rst_reg <= cpu_rst_next;
      err_reg     <= err_next;
    end
  end

  assign mem_we    = (state_reg == S_WRITE);
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign cpu_rst   = cpu_rst_reg;
  assign err       = err_reg;
  assign done      = (state_reg == S_DONE);
  assign busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);

endmodule
